// File: rtl/coremem_pkg.sv
// rtl/coremem_pkg.sv - shared types and constants for the core data-memory port arbiter
package coremem_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int OBI_AW      = 32;
  localparam int OBI_DW      = 32;
  localparam int OBI_BEW     = OBI_DW / 8;

  // Identifies which master issued a transaction
  typedef logic master_id_t;

  // Request payload carried alongside req
  typedef struct packed {
    logic               we;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_BEW-1:0] be;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  // Round-robin pick among requesters; a tie goes to the master that did not win last
  function automatic master_id_t rr_pick(input logic [NUM_MASTERS-1:0] req,
                                         input master_id_t rr_last);
    master_id_t pick;
    pick = 1'b0;
    if (req == 2'b10) begin
      pick = 1'b1;
    end else if (req == 2'b11) begin
      pick = ~rr_last;
    end
    return pick;
  endfunction

endpackage

// File: rtl/coremem_owner_fifo.sv
// rtl/coremem_owner_fifo.sv - in-order FIFO recording which master owns each outstanding transaction
import coremem_pkg::*;

module coremem_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  master_id_t data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output master_id_t head_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  master_id_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Owner storage; written at the tail on every accepted push
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 1'b0;
      end
    end else if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop_ok) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/coremem_port_arbiter.sv
// rtl/coremem_port_arbiter.sv - two-master round-robin arbiter in front of the core data-memory adapter
import coremem_pkg::*;

module coremem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_addr_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_be_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_gnt_o,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  output logic [DW-1:0]                 m_rdata_o,
  output logic                          s_req_o,
  output logic                          s_we_o,
  output logic [AW-1:0]                 s_addr_o,
  output logic [DW/8-1:0]               s_be_o,
  output logic [DW-1:0]                 s_wdata_o,
  input  logic                          s_gnt_i,
  input  logic                          s_rvalid_i,
  input  logic [DW-1:0]                 s_rdata_i,
  output logic                          err_o
);

  localparam int BW = DW / 8;

  master_id_t sel;
  master_id_t rr_last_q;
  master_id_t lock_id_q;
  master_id_t head;
  logic       lock_q;
  logic       lock_active;
  logic       fifo_full;
  logic       fifo_empty;
  logic       issue;
  logic       grant;
  logic       pop;

  // A lock only holds while its owner keeps requesting; a dropped req releases it
  assign lock_active = lock_q & m_req_i[lock_id_q];

  // Master selection: a stalled request keeps the port, otherwise round-robin
  always_comb begin
    sel = rr_pick(m_req_i, rr_last_q);
    if (lock_active) begin
      sel = lock_id_q;
    end
  end

  // Issue is gated only by registered occupancy, so rvalid never reaches req/gnt combinationally
  assign issue = m_req_i[sel] & ~fifo_full & ~rst_i;
  assign grant = issue & s_gnt_i;
  assign pop   = s_rvalid_i & ~fifo_empty & ~rst_i;

  assign s_req_o = issue;

  // Payload mux from the selected master; zeroed when nothing is issued
  always_comb begin
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (issue) begin
      if (sel) begin
        s_we_o    = m_we_i[1];
        s_addr_o  = m_addr_i[AW +: AW];
        s_be_o    = m_be_i[BW +: BW];
        s_wdata_o = m_wdata_i[DW +: DW];
      end else begin
        s_we_o    = m_we_i[0];
        s_addr_o  = m_addr_i[0 +: AW];
        s_be_o    = m_be_i[0 +: BW];
        s_wdata_o = m_wdata_i[0 +: DW];
      end
    end
  end

  // Grant and response steering back to the individual masters
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (grant) begin
      m_gnt_o[sel] = 1'b1;
    end
    if (pop) begin
      m_rvalid_o[head] = 1'b1;
    end
  end

  assign m_rdata_o = s_rdata_i;

  // Round-robin history and stall lock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last_q <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (grant) begin
        rr_last_q <= sel;
        lock_q    <= 1'b0;
      end else if (issue) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end else if (!lock_active) begin
        lock_q    <= 1'b0;
      end
    end
  end

  // Sticky error for a response arriving with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (s_rvalid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

  coremem_owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

endmodule

// File: tb/tb_coremem_port_arbiter.sv
// tb/tb_coremem_port_arbiter.sv - directed self-checking bench for coremem_port_arbiter
module tb_coremem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk_i;
  logic            rst_i;
  logic [1:0]      m_req_i;
  logic [1:0]      m_we_i;
  logic [2*AW-1:0] m_addr_i;
  logic [2*DW/8-1:0] m_be_i;
  logic [2*DW-1:0] m_wdata_i;
  logic [1:0]      m_gnt_o;
  logic [1:0]      m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_req_o;
  logic            s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW/8-1:0] s_be_o;
  logic [DW-1:0]   s_wdata_o;
  logic            s_gnt_i;
  logic            s_rvalid_i;
  logic [DW-1:0]   s_rdata_i;
  logic            err_o;

  int checks;
  int errors;

  coremem_port_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .MAX_OUTST (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_req_i    (m_req_i),
    .m_we_i     (m_we_i),
    .m_addr_i   (m_addr_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_o   (s_addr_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .err_o      (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m_req_i    = 2'b00;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    next();
    next();
    rst_i = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_i      = 1'b1;
    m_req_i    = 2'b11;
    m_we_i     = 2'b00;
    m_addr_i   = {32'h0000_0200, 32'h0000_0100};
    m_be_i     = 8'hFF;
    m_wdata_i  = '0;
    s_gnt_i    = 1'b1;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h0;

    // Outputs quiet while reset is held, even with live inputs
    next();
    settle();
    check("rst_gnt", m_gnt_o, 2'b00);
    check("rst_req", s_req_o, 1'b0);
    check("rst_rvalid", m_rvalid_o, 2'b00);
    check("rst_err", err_o, 1'b0);
    idle_inputs();
    next();
    rst_i = 1'b0;

    // Single master read with response one cycle later
    m_req_i = 2'b01; s_gnt_i = 1'b1;
    settle();
    check("single_gnt", m_gnt_o, 2'b01);
    check("single_addr", s_addr_o, 32'h100);
    check("single_we", s_we_o, 1'b0);
    next();
    idle_inputs();
    s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    settle();
    check("single_rvalid", m_rvalid_o, 2'b01);
    check("single_rdata", m_rdata_o, 32'hDEADBEEF);
    next();
    idle_inputs();

    // Tie after reset: m0, m1, m0, m1 with responses trailing by one cycle
    do_reset();
    m_req_i = 2'b11; s_gnt_i = 1'b1;
    settle();
    check("tie_g0", m_gnt_o, 2'b01);
    check("tie_g0_addr", s_addr_o, 32'h100);
    next();
    s_rvalid_i = 1'b1;
    settle();
    check("tie_g1", m_gnt_o, 2'b10);
    check("tie_g1_addr", s_addr_o, 32'h200);
    check("tie_r0", m_rvalid_o, 2'b01);
    next();
    settle();
    check("tie_g2", m_gnt_o, 2'b01);
    check("tie_r1", m_rvalid_o, 2'b10);
    next();
    settle();
    check("tie_g3", m_gnt_o, 2'b10);
    check("tie_r2", m_rvalid_o, 2'b01);
    next();
    m_req_i = 2'b00; s_gnt_i = 1'b0;
    settle();
    check("tie_r3", m_rvalid_o, 2'b10);
    next();
    idle_inputs();

    // Make m0 the last winner so an unlocked tie would go to m1
    m_req_i = 2'b01; s_gnt_i = 1'b1;
    next();
    s_rvalid_i = 1'b1; s_gnt_i = 1'b0;
    settle();
    check("pre_lock_rvalid", m_rvalid_o, 2'b01);
    check("stall0_gnt", m_gnt_o, 2'b00);
    check("stall0_addr", s_addr_o, 32'h100);
    next();
    s_rvalid_i = 1'b0; m_req_i = 2'b11;
    settle();
    check("stall1_addr", s_addr_o, 32'h100);
    check("stall1_req", s_req_o, 1'b1);
    next();
    settle();
    check("stall2_addr", s_addr_o, 32'h100);
    next();
    s_gnt_i = 1'b1;
    settle();
    check("stall_gnt_m0", m_gnt_o, 2'b01);
    next();
    m_req_i = 2'b10;
    settle();
    check("stall_gnt_m1", m_gnt_o, 2'b10);
    check("stall_m1_addr", s_addr_o, 32'h200);

    // FIFO now holds two entries: issue blocked, including the cycle an rvalid pops
    next();
    m_req_i = 2'b01;
    settle();
    check("full_req", s_req_o, 1'b0);
    check("full_gnt", m_gnt_o, 2'b00);
    s_rvalid_i = 1'b1;
    #1;
    check("full_pop_req", s_req_o, 1'b0);
    check("full_pop_rvalid", m_rvalid_o, 2'b01);
    next();
    s_rvalid_i = 1'b0;
    settle();
    check("after_pop_req", s_req_o, 1'b1);
    check("after_pop_gnt", m_gnt_o, 2'b01);
    next();
    m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    settle();
    check("drain_r_m1", m_rvalid_o, 2'b10);
    next();
    settle();
    check("drain_r_m0", m_rvalid_o, 2'b01);
    next();
    idle_inputs();

    // Response routing: m1 write, then m0 read
    m_we_i = 2'b10; m_wdata_i = {32'hCAFE0001, 32'h0}; m_be_i = 8'h3F;
    m_req_i = 2'b10; s_gnt_i = 1'b1;
    settle();
    check("route_g_m1", m_gnt_o, 2'b10);
    check("route_we", s_we_o, 1'b1);
    check("route_wdata", s_wdata_o, 32'hCAFE0001);
    check("route_be", s_be_o, 4'h3);
    next();
    m_req_i = 2'b01;
    settle();
    check("route_g_m0", m_gnt_o, 2'b01);
    check("route_we0", s_we_o, 1'b0);
    check("route_be0", s_be_o, 4'hF);
    next();
    m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0;
    settle();
    check("route_r1", m_rvalid_o, 2'b10);
    check("idle_wdata", s_wdata_o, 32'h0);
    check("idle_we", s_we_o, 1'b0);
    next();
    s_rdata_i = 32'h12345678;
    settle();
    check("route_r2", m_rvalid_o, 2'b01);
    check("route_rdata", m_rdata_o, 32'h12345678);
    next();
    m_we_i = 2'b00;

    // Spurious response with empty FIFO
    settle();
    check("spur_rvalid", m_rvalid_o, 2'b00);
    check("spur_err_before", err_o, 1'b0);
    next();
    s_rvalid_i = 1'b0;
    settle();
    check("spur_err", err_o, 1'b1);
    next();
    next();
    settle();
    check("spur_err_sticky", err_o, 1'b1);

    // Fill the FIFO, then reset asynchronously mid-cycle
    next();
    m_req_i = 2'b01; s_gnt_i = 1'b1;
    next();
    next();
    settle();
    check("pre_rst_full", s_req_o, 1'b0);
    rst_i = 1'b1;
    #1;
    check("async_rst_err", err_o, 1'b0);
    check("async_rst_req", s_req_o, 1'b0);
    next();
    rst_i = 1'b0; s_gnt_i = 1'b0;
    settle();
    check("post_rst_req", s_req_o, 1'b1);
    s_rvalid_i = 1'b1;
    #1;
    check("post_rst_empty", m_rvalid_o, 2'b00);
    next();
    idle_inputs();
    settle();
    check("post_rst_err", err_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coremem_port_arbiter.md
Name: coremem_port_arbiter

Overview:
- Two-master arbiter sitting directly upstream of the core data-memory adapter.
- Merges master 0 (core LSU data port) and master 1 (debug/loader port) onto one req/gnt/rvalid port; that port drives the adapter's data_req_i/data_we_i and takes its data_gnt_o/data_rvalid_o.
- Round-robin arbitration, request locking while stalled, and an in-order owner FIFO that routes each rvalid/rdata back to the issuing master.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables DW/8)
MAX_OUTST, 2, max granted-but-unanswered transactions (owner FIFO depth, >=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
m_req_i  in  2  per-master request (bit n = master n)
m_we_i  in  2  per-master write enable
m_addr_i  in  2*AW  per-master address, master n at [n*AW +: AW]
m_be_i  in  2*DW/8  per-master byte enables
m_wdata_i  in  2*DW  per-master write data
m_gnt_o  out  2  per-master grant
m_rvalid_o  out  2  per-master response valid
m_rdata_o  out  DW  response data, shared by both masters
s_req_o  out  1  downstream request
s_we_o  out  1  downstream write enable
s_addr_o  out  AW  downstream address
s_be_o  out  DW/8  downstream byte enables
s_wdata_o  out  DW  downstream write data
s_gnt_i  in  1  downstream grant, same cycle as s_req_o
s_rvalid_i  in  1  downstream response valid, >=1 cycle after its grant
s_rdata_i  in  DW  downstream read data
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i high, asynchronous): owner FIFO empty, lock cleared, rr_last=1 (master 0 wins the first tie), err_o=0. All gnt/rvalid/req outputs are 0 while in reset.
- Masters hold req and all payload stable until their gnt. Downstream is held to the same rule.
- Selection:
  - If lock is set, the locked master is selected.
  - Otherwise, if exactly one master requests, it is selected.
  - Otherwise, if both request, select the master != rr_last.
- Issue: s_req_o = selected master's req AND NOT fifo_full. s_we/addr/be/wdata are muxed from the selected master and are 0 when s_req_o=0.
- Grant: m_gnt_o[sel] = s_gnt_i AND s_req_o, combinationally, in the same cycle. The other master's gnt is 0.
- On grant: push sel into the owner FIFO, set rr_last=sel, clear lock.
- Lock: if s_req_o=1 and s_gnt_i=0, set lock to sel. Arbitration cannot switch masters under a pending request.
- fifo_full blocks issue even if an rvalid pops in the same cycle. There is no combinational path from s_rvalid_i to s_gnt/s_req. Full lasts one extra cycle.
- Response:
  - m_rvalid_o[head] = s_rvalid_i when the FIFO is non-empty.
  - m_rdata_o = s_rdata_i, passed through combinationally with zero latency.
  - The FIFO pops on s_rvalid_i.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged. The response goes to the old head.
- s_rvalid_i with an empty FIFO: the response is dropped, no m_rvalid_o is raised, and err_o is set sticky until reset.
- Master drops req before gnt: protocol violation, not detected. Lock clears when the locked master's req goes low.
- Reset mid-transaction: outstanding entries are discarded. The downstream adapter is reset by the same domain.
- FIFO count width is $clog2(MAX_OUTST+1). Pointers wrap modulo MAX_OUTST.

Decomposition:
- Package coremem_pkg: localparam NUM_MASTERS=2, typedef master_id_t (1 bit), and the OBI request struct {we, addr, be, wdata} with widths set from the package constants.
- One sub-module, coremem_owner_fifo: a parameterised DEPTH x 1-bit synchronous FIFO with push/pop/full/empty/head and async active-high reset.

Test Plan:
- Single master: m_req_i=01, read addr 0x100, s_gnt_i=1 -> m_gnt_o=01 in the same cycle; s_rvalid_i one cycle later with rdata 0xDEADBEEF -> m_rvalid_o=01 and m_rdata_o=0xDEADBEEF.
- Tie after reset: m_req_i=11 held for 4 grants -> grant order m0, m1, m0, m1.
- Stall lock: m_req_i=01 with s_gnt_i=0 for 3 cycles, m1 raises req in cycle 1 -> s_addr_o stays m0's address; m0 is granted first and m1 next.
- Full FIFO with MAX_OUTST=2: two grants, no rvalid -> s_req_o=0. rvalid in cycle N -> s_req_o=1 again in cycle N+1, not N.
- Response routing: grant m1 (write), then m0 (read) -> first rvalid goes to m_rvalid_o=10, second to 01.
- Spurious rvalid: s_rvalid_i=1 with an empty FIFO -> m_rvalid_o=00 and err_o=1 sticky. Asserting rst_i mid-transaction -> err_o=0 and count=0 immediately.
